mips_seq_alu: RTL and testbench
===============================

Name: mips_seq_alu

Overview:
- Parametrised, clocked successor of the team's combinational MIPS ALU.
- Keeps the single-cycle logic/arithmetic ops and their ALUCtl encodings. Adds signed/unsigned compare, signed overflow, and iterative unsigned multiply/divide writing HI/LO.
- Sits between the ALU control decoder and the register-file writeback.
- Uses a Start/Busy/Done handshake so the datapath can stall on multicycle ops.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- Derived: CW = clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only when Busy=0
- ALUCtl  input  4  operation select, sampled with Start
- A  input  WIDTH  operand A, sampled with Start
- B  input  WIDTH  operand B, sampled with Start
- Busy  output  1  high while an op is in flight
- Done  output  1  one-cycle pulse: result valid
- ALUOut  output  WIDTH  result, or LO for MULTU/DIVU; held until the next Done
- HI  output  WIDTH  high product word / remainder; updated only by MULTU/DIVU
- Zero  output  1  (ALUOut==0), registered with ALUOut
- Overflow  output  1  signed overflow of ADD/SUB; 0 for all other ops
- DivZero  output  1  set by DIVU with B==0; cleared by any other completed op

Behaviour:
- Reset: synchronous, active-high, overrides everything including an in-flight op.
  - State returns to IDLE.
  - Busy=0, Done=0, ALUOut=0, HI=0, Zero=1, Overflow=0, DivZero=0, counter=0.
- States:
  - IDLE: Start=1 latches ALUCtl, A, B.
    - Single-cycle op: go to FIN.
    - 3 or 4: load the iteration engine, counter=WIDTH, go to ITER.
  - ITER: one shift-add (MULTU) or restoring shift-subtract (DIVU) step per cycle; counter decrements; at counter==1 the final step completes and the state goes to FIN.
  - FIN: registers ALUOut/HI/flags, Done=1 for exactly this cycle, returns to IDLE.
- Busy is 1 in ITER and FIN, 0 in IDLE.
- Start while Busy=1 is ignored (no queueing).
- Back-to-back ops: Start may be asserted in the cycle after Done.
- Latency, with Start sampled at edge t:
  - single-cycle ops: Done high in the cycle following edge t+1 (latency 1);
  - MULTU/DIVU: Done high after edge t+WIDTH+1.
- Single-cycle ops (WIDTH-bit, wraparound arithmetic):
  - 0 AND
  - 1 OR
  - 2 ADD: Overflow = sign(A)==sign(B) and sign(sum)!=sign(A)
  - 6 SUB: Overflow = sign(A)!=sign(B) and sign(diff)!=sign(A)
  - 7 SLT: signed compare, result 1/0 zero-extended
  - 8 SLTU: unsigned compare
  - 12 NOR
  - any other code: ALUOut=0, Done after 1 cycle, no fault
- MULTU: unsigned 2*WIDTH-bit product; {HI,ALUOut}=A*B.
- DIVU: unsigned; ALUOut=A/B, HI=A%B.
  - B==0: no iteration (goes straight to FIN, latency 1); ALUOut=all ones, HI=A, DivZero=1.
- Flags:
  - Overflow and DivZero are valid only on the Done cycle and held until the next Done.
  - HI is unchanged by single-cycle ops.
- Outputs other than Busy/Done do not change between Done pulses; intermediate iteration values are never visible on ALUOut/HI.
- Reset asserted during ITER aborts the op; no Done is produced.

Test Plan (WIDTH=32):
- ADD: A=0x7FFFFFFF, B=0x00000001, Ctl=2 -> Done 1 cycle later; ALUOut=0x80000000, Overflow=1, Zero=0. Then SUB A=B=0x5 -> ALUOut=0, Zero=1, Overflow=0.
- Compare: A=0xFFFFFFFF, B=0x1.
  - Ctl=7 (SLT) -> ALUOut=1.
  - Ctl=8 (SLTU) -> ALUOut=0.
  - Ctl=12 (NOR) with A=B=0 -> ALUOut=0xFFFFFFFF.
- MULTU: A=0xFFFFFFFF, B=0x2 -> Busy high 33 cycles, Done at edge t+33; HI=0x00000001, ALUOut=0xFFFFFFFE. A Start pulse mid-op is ignored.
- DIVU: A=100, B=7 -> after 33 cycles ALUOut=14, HI=2, DivZero=0. Then A=0x1234, B=0 -> Done after 1 cycle; ALUOut=0xFFFFFFFF, HI=0x1234, DivZero=1.
- Reset: assert reset on cycle 10 of a MULTU -> next cycle Busy=0, ALUOut=0, HI=0, Zero=1, and no Done pulse. A new ADD 3+4 after reset -> ALUOut=7.
- Unknown Ctl=15 with A=B=0xFFFF -> Done after 1 cycle, ALUOut=0, Zero=1, HI unchanged from the previous MULTU/DIVU.

Source files
------------

// File: rtl/mips_seq_alu.sv
// rtl/mips_seq_alu.sv - clocked MIPS ALU with iterative MULTU/DIVU and Start/Busy/Done handshake
module mips_seq_alu #(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       ALUCtl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUOut,
    output logic [WIDTH-1:0] HI,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivZero
);
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_MULT = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd12;

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    state_t           state;
    logic [3:0]       op;
    logic [WIDTH-1:0] a_r, b_r;
    logic [WIDTH-1:0] hi_acc, lo_acc;
    logic [CW-1:0]    cnt;
    logic             dz;

    logic [WIDTH-1:0] res, sum, diff;
    logic             ovf;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    assign Busy = (state != IDLE);

    always_comb begin
        sum  = a_r + b_r;
        diff = a_r - b_r;
        res  = '0;
        ovf  = 1'b0;
        case (op)
            OP_AND:  res = a_r & b_r;
            OP_OR:   res = a_r | b_r;
            OP_ADD: begin
                res = sum;
                ovf = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a_r < b_r)};
            OP_NOR:  res = ~(a_r | b_r);
            default: res = '0;
        endcase
    end

    // Multiply: {hi_acc,lo_acc} holds partial product and remaining multiplier bits.
    // Divide: hi_acc is the running remainder, lo_acc shifts dividend out and quotient in.
    always_comb begin
        mul_sum = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, a_r} : '0);
        shifted = {hi_acc, lo_acc[WIDTH-1]};
        ge      = (shifted >= {1'b0, b_r});
        div_rem = shifted[WIDTH-1:0] - b_r;
        if (op == OP_MULT) begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], lo_acc[WIDTH-1:1]};
        end else begin
            iter_hi = ge ? div_rem : shifted[WIDTH-1:0];
            iter_lo = {lo_acc[WIDTH-2:0], ge};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op       <= '0;
            a_r      <= '0;
            b_r      <= '0;
            hi_acc   <= '0;
            lo_acc   <= '0;
            cnt      <= '0;
            dz       <= 1'b0;
            Done     <= 1'b0;
            ALUOut   <= '0;
            HI       <= '0;
            Zero     <= 1'b1;
            Overflow <= 1'b0;
            DivZero  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        op  <= ALUCtl;
                        a_r <= A;
                        b_r <= B;
                        dz  <= 1'b0;
                        if (ALUCtl == OP_MULT) begin
                            hi_acc <= '0;
                            lo_acc <= B;
                            cnt    <= CW'(WIDTH);
                            state  <= ITER;
                        end else if (ALUCtl == OP_DIV) begin
                            if (B == '0) begin
                                hi_acc <= A;
                                lo_acc <= '1;
                                dz     <= 1'b1;
                                state  <= FIN;
                            end else begin
                                hi_acc <= '0;
                                lo_acc <= A;
                                cnt    <= CW'(WIDTH);
                                state  <= ITER;
                            end
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                ITER: begin
                    hi_acc <= iter_hi;
                    lo_acc <= iter_lo;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= FIN;
                end
                FIN: begin
                    Done  <= 1'b1;
                    state <= IDLE;
                    if (op == OP_MULT || op == OP_DIV) begin
                        ALUOut   <= lo_acc;
                        HI       <= hi_acc;
                        Zero     <= (lo_acc == '0);
                        Overflow <= 1'b0;
                        DivZero  <= dz;
                    end else begin
                        ALUOut   <= res;
                        Zero     <= (res == '0);
                        Overflow <= ovf;
                        DivZero  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_seq_alu.sv
// tb/tb_mips_seq_alu.sv - scoreboard bench for mips_seq_alu with directed vectors
module tb_mips_seq_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic [3:0]   ALUCtl;
    logic [W-1:0] A, B;
    logic         Busy, Done, Zero, Overflow, DivZero;
    logic [W-1:0] ALUOut, HI;

    mips_seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .Start(Start), .ALUCtl(ALUCtl), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .ALUOut(ALUOut), .HI(HI), .Zero(Zero),
        .Overflow(Overflow), .DivZero(DivZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] out;
        logic [W-1:0] hi;
        logic         zero;
        logic         ovf;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per Done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (Done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got Done=1 expected no pending op");
                end else begin
                    e = sb.pop_front();
                    check({e.name, ".ALUOut"},   ALUOut,          e.out);
                    check({e.name, ".HI"},       HI,              e.hi);
                    check({e.name, ".Zero"},     W'(Zero),        W'(e.zero));
                    check({e.name, ".Overflow"}, W'(Overflow),    W'(e.ovf));
                    check({e.name, ".DivZero"},  W'(DivZero),     W'(e.dz));
                end
            end
        end
    end

    // Issue one op; optionally poke Start mid-flight to show it is ignored.
    task automatic run(input string name, input logic [3:0] ctl, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eo, input logic [W-1:0] eh,
                       input logic ez, input logic ev, input logic ed, input int lat,
                       input int poke_at);
        exp_t e;
        int   busy_cnt;
        int   k;
        e.name = name; e.out = eo; e.hi = eh; e.zero = ez; e.ovf = ev; e.dz = ed;
        @(negedge clk);
        sb.push_back(e);
        Start = 1'b1; ALUCtl = ctl; A = a; B = b;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        busy_cnt = (Busy === 1'b1) ? 1 : 0;
        k = 0;
        while (k < 100) begin
            k++;
            if (k == poke_at) begin
                Start = 1'b1; ALUCtl = 4'd2; A = 32'd1; B = 32'd1;
            end
            @(posedge clk);
            @(negedge clk);
            Start = 1'b0;
            if (Busy === 1'b1) busy_cnt++;
            if (Done === 1'b1) break;
        end
        check({name, ".latency"}, W'(k), W'(lat));
        check({name, ".busy_cycles"}, W'(busy_cnt), W'(lat));
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; ALUCtl = '0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.Busy",     W'(Busy),     32'd0);
        check("reset.Done",     W'(Done),     32'd0);
        check("reset.ALUOut",   ALUOut,       32'd0);
        check("reset.HI",       HI,           32'd0);
        check("reset.Zero",     W'(Zero),     32'd1);
        check("reset.Overflow", W'(Overflow), 32'd0);
        check("reset.DivZero",  W'(DivZero),  32'd0);
        reset = 1'b0;

        run("add_ovf",  4'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 0, 1, 0, 1, 0);
        run("sub_zero", 4'd6,  32'h5,        32'h5,        32'h0,        32'h0, 1, 0, 0, 1, 0);
        run("sub_ovf",  4'd6,  32'h80000000, 32'h1,        32'h7FFFFFFF, 32'h0, 0, 1, 0, 1, 0);
        run("slt",      4'd7,  32'hFFFFFFFF, 32'h1,        32'h1,        32'h0, 0, 0, 0, 1, 0);
        run("sltu",     4'd8,  32'hFFFFFFFF, 32'h1,        32'h0,        32'h0, 1, 0, 0, 1, 0);
        run("nor",      4'd12, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0, 0, 0, 0, 1, 0);
        run("and",      4'd0,  32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 32'h0, 0, 0, 0, 1, 0);
        run("or",       4'd1,  32'hF0F01234, 32'h0FF0FF00, 32'hFFF0FF34, 32'h0, 0, 0, 0, 1, 0);
        run("multu",    4'd3,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 32'h1, 0, 0, 0, 33, 12);
        run("multu_max",4'd3,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0, 0, 0, 33, 0);
        run("divu",     4'd4,  32'd100,      32'd7,        32'd14,       32'd2, 0, 0, 0, 33, 0);
        run("divu_z",   4'd4,  32'h1234,     32'h0,        32'hFFFFFFFF, 32'h1234, 0, 0, 1, 1, 0);
        run("unknown",  4'd15, 32'hFFFF,     32'hFFFF,     32'h0,        32'h1234, 1, 0, 0, 1, 0);

        // Abort a MULTU with reset on its 10th cycle.
        @(negedge clk);
        Start = 1'b1; ALUCtl = 4'd3; A = 32'hFFFFFFFF; B = 32'h3;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort.Busy",   W'(Busy), 32'd0);
        check("abort.Done",   W'(Done), 32'd0);
        check("abort.ALUOut", ALUOut,   32'd0);
        check("abort.HI",     HI,       32'd0);
        check("abort.Zero",   W'(Zero), 32'd1);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        run("add_after_reset", 4'd2, 32'd3, 32'd4, 32'd7, 32'h0, 0, 0, 0, 1, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", W'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
